// File: rtl/io_serial_fifo.sv
// Memory-mapped UART-like peripheral: TX/RX FIFOs, paced transmitter,
// status/control registers and a level RX interrupt on the mode/addr/wdata/rdata bus.
module io_serial_fifo #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned TX_DELAY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   input  logic              rx_in_valid,
   input  logic [DATA_W-1:0] rx_in_data,
   output logic              rx_in_ready,
   output logic              tx_strobe,
   output logic [DATA_W-1:0] tx_data,
   output logic              irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = (TX_DELAY > 1) ? $clog2(TX_DELAY) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(TX_DELAY - 1);

   localparam logic [1:0] MODE_RD    = 2'b01;
   localparam logic [1:0] MODE_WR    = 2'b10;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   // Bus decode
   logic [1:0] sel_c;
   logic       rd_en_c, wr_en_c;
   logic       rd_data_c, wr_data_c, wr_status_c, wr_ctrl_c;

   assign sel_c       = addr[3:2];
   assign rd_en_c     = (mode == MODE_RD);
   assign wr_en_c     = (mode == MODE_WR);
   assign rd_data_c   = rd_en_c && (sel_c == REG_DATA);
   assign wr_data_c   = wr_en_c && (sel_c == REG_DATA);
   assign wr_status_c = wr_en_c && (sel_c == REG_STATUS);
   assign wr_ctrl_c   = wr_en_c && (sel_c == REG_CTRL);

   // RX FIFO: pointers carry an extra wrap bit so full/empty come from the difference
   logic [DATA_W-1:0] rx_mem [DEPTH];
   logic [PW-1:0]     rx_wptr, rx_rptr, rx_count_c;
   logic              rx_full_c, rx_empty_c, rx_push_c, rx_pop_c;

   assign rx_count_c  = rx_wptr - rx_rptr;
   assign rx_full_c   = (rx_count_c == PW'(DEPTH));
   assign rx_empty_c  = (rx_count_c == '0);
   assign rx_in_ready = !rx_full_c;
   assign rx_push_c   = rx_in_valid && !rx_full_c;
   assign rx_pop_c    = rd_data_c && !rx_empty_c;

   always_ff @(posedge clk) begin
      if (rx_push_c) rx_mem[rx_wptr[AW-1:0]] <= rx_in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_wptr <= '0;
         rx_rptr <= '0;
      end else begin
         if (rx_push_c) rx_wptr <= rx_wptr + PW'(1);
         if (rx_pop_c)  rx_rptr <= rx_rptr + PW'(1);
      end
   end

   // TX FIFO
   logic [DATA_W-1:0] tx_mem [DEPTH];
   logic [PW-1:0]     tx_wptr, tx_rptr, tx_count_c;
   logic              tx_full_c, tx_empty_c, tx_push_c, tx_pop_c;

   assign tx_count_c = tx_wptr - tx_rptr;
   assign tx_full_c  = (tx_count_c == PW'(DEPTH));
   assign tx_empty_c = (tx_count_c == '0);
   assign tx_push_c  = wr_data_c && !tx_full_c;

   always_ff @(posedge clk) begin
      if (tx_push_c) tx_mem[tx_wptr[AW-1:0]] <= wdata[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
      end else begin
         if (tx_push_c) tx_wptr <= tx_wptr + PW'(1);
         if (tx_pop_c)  tx_rptr <= tx_rptr + PW'(1);
      end
   end

   // Transmitter FSM
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic              load_c, strobe_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!tx_empty_c) state_d = S_BUSY;
         S_BUSY:  if ((cnt_q == '0) && tx_empty_c) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_pop_c = 1'b0;
      load_c   = 1'b0;
      strobe_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!tx_empty_c) begin
               tx_pop_c = 1'b1;
               load_c   = 1'b1;
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               strobe_c = 1'b1;
               if (!tx_empty_c) begin
                  tx_pop_c = 1'b1;
                  load_c   = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Shift register and pacing counter; the strobe reports the byte before any reload
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         shreg_q   <= '0;
         tx_strobe <= 1'b0;
         tx_data   <= '0;
      end else begin
         if (load_c) begin
            shreg_q <= tx_mem[tx_rptr[AW-1:0]];
            cnt_q   <= CNT_LOAD;
         end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
         end
         tx_strobe <= strobe_c;
         if (strobe_c) tx_data <= shreg_q;
      end
   end

   // Sticky flags, control and interrupt; a new overflow wins over a same-cycle clear
   logic ovf_tx, ovf_rx, irq_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_tx <= 1'b0;
         ovf_rx <= 1'b0;
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_data_c && tx_full_c)            ovf_tx <= 1'b1;
         else if (wr_status_c && wdata[3])      ovf_tx <= 1'b0;
         if (rx_in_valid && rx_full_c)          ovf_rx <= 1'b1;
         else if (wr_status_c && wdata[4])      ovf_rx <= 1'b0;
         if (wr_ctrl_c) irq_en <= wdata[0];
         irq <= irq_en && !rx_empty_c;
      end
   end

   // Read mux
   logic        tx_idle_c;
   logic [31:0] status_c;

   assign tx_idle_c = tx_empty_c && (state_q == S_IDLE);
   assign status_c  = {16'b0, 8'(rx_count_c), 3'b0, ovf_rx, ovf_tx,
                       tx_idle_c, !rx_empty_c, !tx_full_c};

   always_comb begin
      rdata = '0;
      if (rd_en_c) begin
         case (sel_c)
            REG_DATA:   if (!rx_empty_c) rdata = 32'(rx_mem[rx_rptr[AW-1:0]]);
            REG_STATUS: rdata = status_c;
            REG_CTRL:   rdata = {31'b0, irq_en};
            default:    rdata = '0;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{wdata, addr};

endmodule
